display_select_sequencer: RTL and testbench
===========================================

// Module: display_select_sequencer
// PURPOSE
//  Drives Display_Select/Display_Enable of the 32-bit debug hex display mux (17 sources:
//  PC, IR, RA..RY, RF addrs, ROM, PC_Temp, BranchOffset, PC ctrl, CCR, OP_Code, IMM).
//  Steps sources from a debounced pushbutton, auto-scans on a timer, or loads a source
//  directly. Blanks the display for a fixed gap on every change so the operator sees each switch.
// PARAMETERS
//  NUM_SOURCES      17          number of valid select codes, 0..NUM_SOURCES-1 (2..32)
//  DEBOUNCE_CYCLES  500000      consecutive stable cycles needed to accept a button level (>=1)
//  SCAN_PERIOD      50000000    cycles per source in auto-scan (>=2)
//  BLANK_CYCLES     2500000     cycles Display_Enable is held low after each change (>=1)
// PORTS
//  Clock           in   1  system clock; all state updates on rising edge
//  Reset           in   1  synchronous, active-high
//  Step_n          in   1  raw pushbutton, active low, asynchronous to Clock
//  Direction       in   1  0 = step/scan up, 1 = step/scan down
//  Auto_Scan       in   1  1 = advance every SCAN_PERIOD cycles while showing
//  Load            in   1  1-cycle strobe: jump directly to Load_Select
//  Load_Select     in   5  target select code for Load
//  Display_Select  out  5  select code to display mux
//  Display_Enable  out  1  1 = mux shows selected source, 0 = mux shows OFF pattern
//  Select_Changed  out  1  1-cycle pulse on the edge Display_Select takes a new value
//  Load_Error      out  1  1-cycle pulse when Load is rejected (Load_Select >= NUM_SOURCES)
// BEHAVIOUR
//  Reset: Display_Select=0, Display_Enable=0, Select_Changed=0, Load_Error=0; state=BLANK,
//   blank count=0, scan timer=0, debounce counter=0, synced/accepted button level=1.
//  Button: 2-flop synchronizer on Step_n. Debounce counter clears whenever synced level equals
//   accepted level, else increments; on reaching DEBOUNCE_CYCLES accepted level takes synced
//   level and counter clears. Press event = accepted level 1->0 (one event per press;
//   release produces none). Press-to-event latency = 2 + DEBOUNCE_CYCLES cycles.
//  Scan tick: timer counts only in SHOW with Auto_Scan=1; tick when timer = SCAN_PERIOD-1.
//   Timer clears on tick, on any select change, when Auto_Scan=0, and outside SHOW.
//  Request priority (evaluated in SHOW only): Load > press > scan tick; one action per cycle.
//   Lower-priority requests in the same cycle are dropped.
//  Advance: up wraps NUM_SOURCES-1 -> 0; down wraps 0 -> NUM_SOURCES-1.
//  Load with Load_Select < NUM_SOURCES: select := Load_Select (pulse Select_Changed even if
//   equal value). Load_Select >= NUM_SOURCES: no change, Load_Error pulses, stay in SHOW.
//  FSM (2 states):
//   SHOW : Display_Enable=1. Accepted Load/press/tick -> Display_Select updated on same edge,
//          Select_Changed=1 next cycle, Display_Enable=0 next cycle, go BLANK, count=0.
//   BLANK: Display_Enable=0; count++; at count=BLANK_CYCLES-1 -> SHOW (Enable=1 next cycle).
//          Press events and scan ticks during BLANK are discarded. A valid Load during BLANK
//          updates Display_Select, pulses Select_Changed and restarts count at 0; an invalid
//          Load pulses Load_Error only.
//  Outputs are registered; Display_Select never holds a value >= NUM_SOURCES.
//  Reset mid-BLANK or mid-debounce: all state returns to reset values that cycle; a held button
//   is re-accepted as pressed only after release then press.
// TESTING (NUM_SOURCES=17, DEBOUNCE_CYCLES=4, SCAN_PERIOD=10, BLANK_CYCLES=2)
//  Reset 3 cycles, release -> Select=0, Enable=0 two cycles, then Enable=1; no pulses.
//  Step_n low 10 cycles, Dir=0 -> exactly one advance to 1, 6 cycles after fall; Enable low 2.
//  Step_n bounce 1-0-1-0 (1 cycle each) then low -> single advance only after 4 stable cycles.
//  Select=16, Dir=0 press -> 0; Select=0, Dir=1 press -> 16 (wrap both ways).
//  Auto_Scan=1 from Select=5 -> 6,7,8 at 12-cycle spacing (10 SHOW + 2 BLANK).
//  Load=1,Load_Select=20 -> Load_Error pulse, Select unchanged; Load+press same cycle with
//   Load_Select=9 -> Select=9, press dropped; Reset during BLANK -> Select=0 next cycle.

Source files
------------

// File: rtl/display_select_sequencer.sv
// Debug hex display source sequencer: steps the mux select from a debounced
// pushbutton, auto-scans on a timer or loads a code directly, and blanks the
// display for a fixed gap after every change.
module display_select_sequencer #(
  parameter int unsigned NUM_SOURCES     = 17,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SCAN_PERIOD     = 50000000,
  parameter int unsigned BLANK_CYCLES    = 2500000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Step_n,
  input  logic       Direction,
  input  logic       Auto_Scan,
  input  logic       Load,
  input  logic [4:0] Load_Select,
  output logic [4:0] Display_Select,
  output logic       Display_Enable,
  output logic       Select_Changed,
  output logic       Load_Error
);

  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SCAN_W  = $clog2(SCAN_PERIOD);
  localparam int unsigned BLANK_W = $clog2(BLANK_CYCLES + 1);

  localparam logic [4:0]         LAST_SEL   = 5'(NUM_SOURCES - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_PERIOD - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  // button path
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [1:0]       sync_vld_q, sync_vld_d;
  logic             accepted_q, accepted_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             arm_q, arm_d;
  logic             accept_c;
  logic             press_c;

  // sequencer
  state_e             state_q, state_d;
  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [4:0]         sel_q, sel_d;
  logic               en_q, en_d;
  logic               changed_q, changed_d;
  logic               load_err_q, load_err_d;
  logic               load_ok_c;
  logic               load_bad_c;
  logic               scan_tick_c;
  logic               change_c;
  logic [4:0]         next_sel_c;

  // Synchronize, debounce and edge-detect the pushbutton; a press is only
  // honoured once the button has been seen released since reset.
  always_comb begin
    sync1_d    = Step_n;
    sync2_d    = sync1_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
    accepted_d = accepted_q;
    deb_cnt_d  = '0;
    accept_c   = 1'b0;
    if (sync2_q != accepted_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        accepted_d = sync2_q;
        accept_c   = 1'b1;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
    press_c = accept_c & ~sync2_q & arm_q;
    arm_d   = arm_q | (sync_vld_q[1] & sync2_q & accepted_q);
  end

  // Next select code for a step/scan in the current direction, with wrap.
  always_comb begin
    next_sel_c = sel_q;
    if (Direction) begin
      next_sel_c = (sel_q == 5'd0) ? LAST_SEL : sel_q - 5'd1;
    end else begin
      next_sel_c = (sel_q == LAST_SEL) ? 5'd0 : sel_q + 5'd1;
    end
  end

  // SHOW/BLANK state machine: request arbitration, blank gap and scan timer.
  always_comb begin
    state_d     = state_q;
    blank_cnt_d = '0;
    scan_cnt_d  = '0;
    sel_d       = sel_q;
    changed_d   = 1'b0;
    load_err_d  = 1'b0;
    change_c    = 1'b0;
    load_ok_c   = Load & (32'(Load_Select) < NUM_SOURCES);
    load_bad_c  = Load & ~load_ok_c;
    scan_tick_c = (state_q == ST_SHOW) & Auto_Scan & (scan_cnt_q == SCAN_LAST);

    case (state_q)
      ST_SHOW: begin
        if (load_ok_c) begin
          sel_d    = Load_Select;
          change_c = 1'b1;
        end else if (load_bad_c) begin
          load_err_d = 1'b1;
        end else if (press_c || scan_tick_c) begin
          sel_d    = next_sel_c;
          change_c = 1'b1;
        end
        if (change_c) begin
          state_d = ST_BLANK;
        end else if (Auto_Scan && !scan_tick_c) begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
      end
      default: begin
        if (load_ok_c) begin
          sel_d    = Load_Select;
          change_c = 1'b1;
        end else begin
          load_err_d = load_bad_c;
          if (blank_cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
          end else begin
            blank_cnt_d = blank_cnt_q + BLANK_W'(1);
          end
        end
      end
    endcase

    changed_d = change_c;
    en_d      = (state_d == ST_SHOW);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync_vld_q  <= 2'b00;
      accepted_q  <= 1'b1;
      deb_cnt_q   <= '0;
      arm_q       <= 1'b0;
      state_q     <= ST_BLANK;
      blank_cnt_q <= '0;
      scan_cnt_q  <= '0;
      sel_q       <= 5'd0;
      en_q        <= 1'b0;
      changed_q   <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_vld_q  <= sync_vld_d;
      accepted_q  <= accepted_d;
      deb_cnt_q   <= deb_cnt_d;
      arm_q       <= arm_d;
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      sel_q       <= sel_d;
      en_q        <= en_d;
      changed_q   <= changed_d;
      load_err_q  <= load_err_d;
    end
  end

  assign Display_Select = sel_q;
  assign Display_Enable = en_q;
  assign Select_Changed = changed_q;
  assign Load_Error     = load_err_q;

endmodule

// File: tb/tb_display_select_sequencer.sv
// Directed bench for display_select_sequencer with short debounce/scan/blank
// parameters so every behaviour fits in a few hundred cycles.
module tb_display_select_sequencer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Step_n;
  logic       Direction;
  logic       Auto_Scan;
  logic       Load;
  logic [4:0] Load_Select;
  logic [4:0] Display_Select;
  logic       Display_Enable;
  logic       Select_Changed;
  logic       Load_Error;

  int n_checks = 0;
  int n_fail   = 0;

  display_select_sequencer #(
    .NUM_SOURCES    (17),
    .DEBOUNCE_CYCLES(4),
    .SCAN_PERIOD    (10),
    .BLANK_CYCLES   (2)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Step_n        (Step_n),
    .Direction     (Direction),
    .Auto_Scan     (Auto_Scan),
    .Load          (Load),
    .Load_Select   (Load_Select),
    .Display_Select(Display_Select),
    .Display_Enable(Display_Enable),
    .Select_Changed(Select_Changed),
    .Load_Error    (Load_Error)
  );

  always #5 Clock = ~Clock;

  // Advance one clock; sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  // Press the button from idle, check the advance lands 6 cycles after the fall, release.
  task automatic do_press(input string tag, input logic [4:0] prev, input logic [4:0] nxt);
    Step_n = 1'b0;
    repeat (5) tick();
    chk({tag, "_before"}, 32'(Display_Select), 32'(prev));
    tick();
    chk({tag, "_after"}, 32'(Display_Select), 32'(nxt));
    chk({tag, "_changed"}, 32'(Select_Changed), 32'd1);
    Step_n = 1'b1;
    repeat (10) tick();
  endtask

  task automatic do_load(input logic [4:0] code);
    Load        = 1'b1;
    Load_Select = code;
    tick();
    Load        = 1'b0;
    Load_Select = 5'd0;
  endtask

  initial begin
    Reset       = 1'b1;
    Step_n      = 1'b1;
    Direction   = 1'b0;
    Auto_Scan   = 1'b0;
    Load        = 1'b0;
    Load_Select = 5'd0;

    // reset state and blank gap after release
    repeat (3) tick();
    chk("rst_sel", 32'(Display_Select), 32'd0);
    chk("rst_en", 32'(Display_Enable), 32'd0);
    chk("rst_changed", 32'(Select_Changed), 32'd0);
    chk("rst_err", 32'(Load_Error), 32'd0);
    Reset = 1'b0;
    tick();
    chk("post_rst_en0", 32'(Display_Enable), 32'd0);
    chk("post_rst_changed", 32'(Select_Changed), 32'd0);
    tick();
    chk("post_rst_en1", 32'(Display_Enable), 32'd1);
    chk("post_rst_sel", 32'(Display_Select), 32'd0);
    repeat (3) tick();

    // long press: one advance 6 cycles after the fall, blank for 2
    Step_n = 1'b0;
    repeat (5) tick();
    chk("press1_before", 32'(Display_Select), 32'd0);
    tick();
    chk("press1_sel", 32'(Display_Select), 32'd1);
    chk("press1_changed", 32'(Select_Changed), 32'd1);
    chk("press1_en", 32'(Display_Enable), 32'd0);
    tick();
    chk("press1_pulse_end", 32'(Select_Changed), 32'd0);
    chk("press1_blank2", 32'(Display_Enable), 32'd0);
    tick();
    chk("press1_show", 32'(Display_Enable), 32'd1);
    repeat (6) tick();
    chk("press1_held", 32'(Display_Select), 32'd1);
    Step_n = 1'b1;
    repeat (10) tick();
    chk("release_no_event", 32'(Display_Select), 32'd1);

    // bounce 0-1 then steady low: accepted only after 4 stable cycles
    Step_n = 1'b0;
    tick();
    Step_n = 1'b1;
    tick();
    Step_n = 1'b0;
    repeat (5) tick();
    chk("bounce_before", 32'(Display_Select), 32'd1);
    tick();
    chk("bounce_after", 32'(Display_Select), 32'd2);
    Step_n = 1'b1;
    repeat (10) tick();
    chk("bounce_single", 32'(Display_Select), 32'd2);

    // wrap in both directions
    do_load(5'd16);
    chk("load16", 32'(Display_Select), 32'd16);
    repeat (3) tick();
    Direction = 1'b0;
    do_press("wrap_up", 5'd16, 5'd0);
    Direction = 1'b1;
    do_press("wrap_down", 5'd0, 5'd16);
    Direction = 1'b0;

    // auto-scan from 5: changes every 12 cycles after the first
    do_load(5'd5);
    chk("load5", 32'(Display_Select), 32'd5);
    tick();
    tick();
    chk("load5_show", 32'(Display_Enable), 32'd1);
    Auto_Scan = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat ((i == 0) ? 9 : 11) tick();
      chk("scan_hold", 32'(Display_Select), 32'(5 + i));
      tick();
      chk("scan_step", 32'(Display_Select), 32'(6 + i));
      chk("scan_changed", 32'(Select_Changed), 32'd1);
    end
    Auto_Scan = 1'b0;
    repeat (3) tick();

    // out-of-range load
    do_load(5'd20);
    chk("bad_load_err", 32'(Load_Error), 32'd1);
    chk("bad_load_sel", 32'(Display_Select), 32'd8);
    chk("bad_load_nochg", 32'(Select_Changed), 32'd0);
    chk("bad_load_en", 32'(Display_Enable), 32'd1);
    tick();
    chk("bad_load_pulse_end", 32'(Load_Error), 32'd0);

    // load and press on the same edge: load wins, press dropped
    Step_n = 1'b0;
    repeat (5) tick();
    do_load(5'd9);
    chk("load_vs_press_sel", 32'(Display_Select), 32'd9);
    chk("load_vs_press_chg", 32'(Select_Changed), 32'd1);
    // valid load during blank restarts the gap
    do_load(5'd3);
    chk("blank_load_sel", 32'(Display_Select), 32'd3);
    chk("blank_load_chg", 32'(Select_Changed), 32'd1);
    chk("blank_load_en", 32'(Display_Enable), 32'd0);
    tick();
    chk("blank_restart", 32'(Display_Enable), 32'd0);
    tick();
    chk("blank_restart_show", 32'(Display_Enable), 32'd1);
    repeat (4) tick();
    chk("press_dropped", 32'(Display_Select), 32'd3);
    Step_n = 1'b1;
    repeat (10) tick();

    // reset during blank
    do_load(5'd7);
    chk("pre_reset_sel", 32'(Display_Select), 32'd7);
    Reset = 1'b1;
    tick();
    chk("blank_reset_sel", 32'(Display_Select), 32'd0);
    chk("blank_reset_en", 32'(Display_Enable), 32'd0);

    // button held through reset is not a press until released
    Step_n = 1'b0;
    repeat (2) tick();
    Reset = 1'b0;
    repeat (15) tick();
    chk("held_no_press", 32'(Display_Select), 32'd0);
    chk("held_show", 32'(Display_Enable), 32'd1);
    Step_n = 1'b1;
    repeat (10) tick();
    do_press("repress", 5'd0, 5'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
